aes_key_sched_seq: RTL and testbench

// Iterative AES key expansion (FIPS-197 Sec. 5.2). Computes one 32-bit schedule word per clock.

---
 rtl/aes_key_sched_seq.sv | 127 ++++++++++++
 tb/tb_aes_key_sched_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_seq.sv
// Iterative AES key expansion: one 32-bit schedule word per clock.
// Words are held in a register file and presented as the flat round-key vector.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// EXPAND | writing w[i] each clock, i = Nk .. NW-1
// DONE   | schedule complete, keys_valid high, start restarts
module aes_key_sched_seq #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [0:32*Nk-1]        key,
   output logic                    busy,
   output logic                    done,
   output logic                    keys_valid,
   output logic [0:128*(Nr+1)-1]   expanded_keys
);

   localparam int NW = 4 * (Nr + 1);
   localparam int IW = $clog2(NW + 1);
   localparam int PW = $clog2(Nk);
   localparam logic [IW-1:0] NK_I    = IW'(Nk);
   localparam logic [IW-1:0] LAST_I  = IW'(NW - 1);
   localparam logic [PW-1:0] PH_LAST = PW'(Nk - 1);
   localparam logic [PW-1:0] PH_FOUR = PW'(4);

   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[{a, 3'b000} +: 8];
   endfunction

   typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

   state_t          state, state_nx;
   logic [31:0]     w [NW];
   logic [IW-1:0]   idx;
   logic [PW-1:0]   phase;
   logic [7:0]      rcon;
   logic            done_q;
   logic            accept;
   logic            last;
   logic [IW-1:0]   prev_idx, back_idx;
   logic [31:0]     prev, rot, sub_in, sub, temp, next_word;

   assign accept = start && (state == ST_IDLE || state == ST_DONE);
   assign last   = (state == ST_EXPAND) && (idx == LAST_I);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (start)          state_nx = ST_EXPAND;
         ST_EXPAND: if (idx == LAST_I)  state_nx = ST_DONE;
         ST_DONE:   if (start)          state_nx = ST_EXPAND;
         default:                       state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == ST_EXPAND);
      keys_valid = (state == ST_DONE);
      done       = done_q;
   end

   // Indices are clamped so idle/reset values never read outside the word file.
   always_comb begin
      prev_idx  = (idx == '0) ? '0 : idx - 1'b1;
      back_idx  = (idx >= NK_I) ? idx - NK_I : '0;
      prev      = w[prev_idx];
      rot       = {prev[23:0], prev[31:24]};
      sub_in    = (phase == '0) ? rot : prev;
      sub       = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                   sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
      temp      = prev;
      if (phase == '0)
         temp = sub ^ {rcon, 24'h0};
      else if (Nk == 8 && phase == PH_FOUR)
         temp = sub;
      next_word = w[back_idx] ^ temp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < NW; j++) w[j] <= '0;
         idx    <= '0;
         phase  <= '0;
         rcon   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= last;
         if (accept) begin
            for (int j = 0; j < Nk; j++) w[j] <= key[32*j +: 32];
            idx   <= NK_I;
            phase <= '0;
            rcon  <= 8'h01;
         end else if (state == ST_EXPAND) begin
            w[idx] <= next_word;
            idx    <= idx + 1'b1;
            phase  <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            if (phase == '0)
               rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
      end
   end

   for (genvar g = 0; g < NW; g++) begin : g_out
      assign expanded_keys[32*g +: 32] = w[g];
   end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Bench for aes_key_sched_seq: AES-128/192/256 instances checked against FIPS-197
// vectors and a reference expansion built from a GF(2^8)-derived S-box.
module tb_aes_key_sched_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic [0:127] k128 = '0;
   logic [0:191] k192 = '0;
   logic [0:255] k256 = '0;
   logic busy0, done0, kv0, busy1, done1, kv1, busy2, done2, kv2;
   logic [0:1407] ek128;
   logic [0:1663] ek192;
   logic [0:1919] ek256;

   int checks = 0;
   int failures = 0;

   logic [7:0]  ref_sbox [256];
   logic [31:0] ref_w [60];

   always #5 clk = ~clk;

   aes_key_sched_seq #(.Nk(4), .Nr(10)) d128 (.clk(clk), .rst(rst), .start(start0), .key(k128),
      .busy(busy0), .done(done0), .keys_valid(kv0), .expanded_keys(ek128));
   aes_key_sched_seq #(.Nk(6), .Nr(12)) d192 (.clk(clk), .rst(rst), .start(start1), .key(k192),
      .busy(busy1), .done(done1), .keys_valid(kv1), .expanded_keys(ek192));
   aes_key_sched_seq #(.Nk(8), .Nr(14)) d256 (.clk(clk), .rst(rst), .start(start2), .key(k256),
      .busy(busy2), .done(done2), .keys_valid(kv2), .expanded_keys(ek256));

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p = 8'h00; aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h01;
         for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(a));
         if (a == 0) inv = 8'h00;
         ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {ref_sbox[x[31:24]], ref_sbox[x[23:16]], ref_sbox[x[15:8]], ref_sbox[x[7:0]]};
   endfunction

   function automatic int nw_of(input int nk);
      return 4 * (nk + 7);
   endfunction

   task automatic ref_expand(input int nk, input logic [0:255] k);
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < nk; i++) ref_w[i] = k[32*i +: 32];
      for (int i = nk; i < nw_of(nk); i++) begin
         t = ref_w[i-1];
         if (i % nk == 0) begin
            rc = 8'h01;
            for (int r = 1; r < i / nk; r++) rc = gf_mul(rc, 8'h02);
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end else if (nk == 8 && i % nk == 4) begin
            t = sub_word(t);
         end
         ref_w[i] = ref_w[i-nk] ^ t;
      end
   endtask

   // ---------------- DUT access ----------------
   function automatic int nk_of(input int which);
      return (which == 0) ? 4 : (which == 1) ? 6 : 8;
   endfunction

   function automatic logic [31:0] dut_word(input int which, input int idx);
      case (which)
         0:       return ek128[32*idx +: 32];
         1:       return ek192[32*idx +: 32];
         default: return ek256[32*idx +: 32];
      endcase
   endfunction

   function automatic logic [2:0] dut_flags(input int which);
      case (which)
         0:       return {busy0, done0, kv0};
         1:       return {busy1, done1, kv1};
         default: return {busy2, done2, kv2};
      endcase
   endfunction

   function automatic int first_diff(input int which);
      for (int j = 0; j < nw_of(nk_of(which)); j++)
         if (dut_word(which, j) !== ref_w[j]) return j;
      return -1;
   endfunction

   task automatic set_start(input int which, input logic v);
      case (which)
         0:       start0 = v;
         1:       start1 = v;
         default: start2 = v;
      endcase
   endtask

   task automatic set_key(input int which, input logic [0:255] k);
      case (which)
         0:       k128 = k[0:127];
         1:       k192 = k[0:191];
         default: k256 = k;
      endcase
   endtask

   function automatic logic [0:255] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Pulse start for one edge, then count edges until done (bounded).
   task automatic launch(input int which, input logic [0:255] k, output int edges);
      @(negedge clk);
      set_key(which, k);
      set_start(which, 1'b1);
      @(posedge clk); #1;
      set_start(which, 1'b0);
      edges = 0;
      while (dut_flags(which)[1] !== 1'b1 && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (dut_flags(d) !== 3'b000) begin
            failures++; $display("FAIL reset_flags dut%0d: busy/done/kv=%b want 000", d, dut_flags(d));
         end
      end
      checks++;
      if (ek128 !== '0 || ek192 !== '0 || ek256 !== '0) begin
         failures++; $display("FAIL reset_words: nonzero word w0=%h want 0", dut_word(0, 0));
      end
   endtask

   task automatic test_vectors(input int which, input logic [0:255] k);
      int edges, d;
      launch(which, k, edges);
      ref_expand(nk_of(which), k);
      checks++;
      if (edges != nw_of(nk_of(which)) - nk_of(which)) begin
         failures++; $display("FAIL latency dut%0d: %0d edges want %0d", which, edges,
                              nw_of(nk_of(which)) - nk_of(which));
      end
      checks++;
      if (dut_flags(which) !== 3'b011) begin
         failures++; $display("FAIL done_flags dut%0d: %b want 011", which, dut_flags(which));
      end
      d = first_diff(which);
      checks++;
      if (d != -1) begin
         failures++; $display("FAIL model dut%0d: w[%0d]=%h want %h", which, d, dut_word(which, d), ref_w[d]);
      end
   endtask

   task automatic test_fips();
      test_vectors(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
      checks++; if (dut_word(0, 4) !== 32'ha0fafe17) begin
         failures++; $display("FAIL aes128_w4: %h want a0fafe17", dut_word(0, 4)); end
      checks++; if (dut_word(0, 43) !== 32'hb6630ca6) begin
         failures++; $display("FAIL aes128_w43: %h want b6630ca6", dut_word(0, 43)); end
      test_vectors(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
      checks++; if (dut_word(1, 6) !== 32'hfe0c91f7) begin
         failures++; $display("FAIL aes192_w6: %h want fe0c91f7", dut_word(1, 6)); end
      checks++; if (dut_word(1, 51) !== 32'h01002202) begin
         failures++; $display("FAIL aes192_w51: %h want 01002202", dut_word(1, 51)); end
      test_vectors(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
      checks++; if (dut_word(2, 8) !== 32'h9ba35411) begin
         failures++; $display("FAIL aes256_w8: %h want 9ba35411", dut_word(2, 8)); end
      checks++; if (dut_word(2, 12) !== 32'ha8b09c1a) begin
         failures++; $display("FAIL aes256_w12: %h want a8b09c1a", dut_word(2, 12)); end
      checks++; if (dut_word(2, 59) !== 32'h706c631e) begin
         failures++; $display("FAIL aes256_w59: %h want 706c631e", dut_word(2, 59)); end
   endtask

   task automatic test_handshake();
      logic [0:255] k;
      int edges, d;
      k = rand_key();
      ref_expand(4, k);
      @(negedge clk); k128 = k[0:127]; start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      edges = 0;
      repeat (16) begin @(posedge clk); #1 edges++; end
      @(negedge clk); start0 = 1'b1; k128 = ~k[0:127];
      @(posedge clk); #1 start0 = 1'b0; edges++;
      while (done0 !== 1'b1 && edges < 100) begin @(posedge clk); #1 edges++; end
      checks++;
      if (edges != 40) begin
         failures++; $display("FAIL midrun_start_latency: %0d edges want 40", edges);
      end
      d = first_diff(0);
      checks++;
      if (d != -1) begin
         failures++; $display("FAIL midrun_start_result: w[%0d]=%h want %h", d, dut_word(0, d), ref_w[d]);
      end
      // abort a run with reset
      @(negedge clk); k128 = rand_key() >> 128; start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      checks++;
      if ({busy0, done0, kv0} !== 3'b000 || ek128 !== '0) begin
         failures++; $display("FAIL abort_reset: flags=%b w0=%h want 000 and 0", {busy0, done0, kv0}, ek128[0:31]);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (busy0 !== 1'b0) begin
         failures++; $display("FAIL abort_stays_idle: busy=%b want 0", busy0);
      end
      test_vectors(0, rand_key());
   endtask

   task automatic test_restart();
      int edges, pulses, done_edge, d;
      logic [0:255] k;
      // key changes while sitting in DONE must not disturb the schedule
      repeat (3) begin @(negedge clk); k128 = rand_key() >> 128; end
      @(posedge clk); #1;
      d = first_diff(0);
      checks++;
      if (d != -1 || kv0 !== 1'b1) begin
         failures++; $display("FAIL key_change_ignored: kv=%b diff_word=%0d want kv=1 diff=-1", kv0, d);
      end
      k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      ref_expand(4, k);
      @(negedge clk); k128 = k[0:127]; start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      checks++;
      if (kv0 !== 1'b0 || busy0 !== 1'b1) begin
         failures++; $display("FAIL restart_kv_drop: kv=%b busy=%b want 0 1", kv0, busy0);
      end
      edges = 0; pulses = 0; done_edge = -1;
      while (edges < 46) begin
         @(posedge clk); #1 edges++;
         if (done0 === 1'b1) begin pulses++; done_edge = edges; end
      end
      checks++;
      if (pulses != 1 || done_edge != 40) begin
         failures++; $display("FAIL restart_done_pulse: pulses=%0d at edge %0d want 1 at 40", pulses, done_edge);
      end
      checks++;
      if (kv0 !== 1'b1 || dut_word(0, 40) !== 32'h13111d7f || dut_word(0, 43) !== 32'h4d2b30c5) begin
         failures++; $display("FAIL restart_vector: kv=%b w40=%h w43=%h want 1 13111d7f 4d2b30c5",
                              kv0, dut_word(0, 40), dut_word(0, 43));
      end
      d = first_diff(0);
      checks++;
      if (d != -1) begin
         failures++; $display("FAIL restart_model: w[%0d]=%h want %h", d, dut_word(0, d), ref_w[d]);
      end
   endtask

   task automatic test_start_held();
      int e1, e2, d;
      logic [0:255] k;
      k = rand_key();
      ref_expand(6, k);
      @(negedge clk); k192 = k[0:191]; start1 = 1'b1;
      @(posedge clk); #1;
      e1 = 0;
      while (done1 !== 1'b1 && e1 < 100) begin @(posedge clk); #1 e1++; end
      checks++;
      if (e1 != 46 || kv1 !== 1'b1) begin
         failures++; $display("FAIL held_first_run: %0d edges kv=%b want 46 1", e1, kv1);
      end
      @(posedge clk); #1;
      checks++;
      if (kv1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
         failures++; $display("FAIL held_restart: kv/busy/done=%b%b%b want 010", kv1, busy1, done1);
      end
      @(negedge clk); start1 = 1'b0;
      e2 = 0;
      while (done1 !== 1'b1 && e2 < 100) begin @(posedge clk); #1 e2++; end
      d = first_diff(1);
      checks++;
      if (e2 != 46 || d != -1) begin
         failures++; $display("FAIL held_second_run: %0d edges diff_word=%0d want 46 -1", e2, d);
      end
   endtask

   task automatic test_random();
      int which, edges, d;
      logic [0:255] k;
      for (int n = 0; n < 200; n++) begin
         which = (n < 140) ? 0 : (n < 170) ? 1 : 2;
         k = rand_key();
         launch(which, k, edges);
         ref_expand(nk_of(which), k);
         checks++;
         if (edges != nw_of(nk_of(which)) - nk_of(which)) begin
            failures++; $display("FAIL rand_latency run %0d dut%0d: %0d edges", n, which, edges);
         end
         d = first_diff(which);
         checks++;
         if (d != -1 || dut_flags(which)[0] !== 1'b1) begin
            failures++; $display("FAIL rand_model run %0d dut%0d: w[%0d]=%h want %h", n, which,
                                 d, dut_word(which, (d < 0) ? 0 : d), ref_w[(d < 0) ? 0 : d]);
         end
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips();
      test_handshake();
      test_restart();
      test_start_held();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
